// File: rtl/e203_nice_csr_resp.sv
// Responder-side CSR bank for the NICE CSR window (0xE00-0xEFF): config regs,
// cycle counter, ID and access counter behind a programmable-latency handshake.
module e203_nice_csr_resp #(
  parameter int          LAT     = 1,
  parameter int          NUM_CSR = 4,
  parameter logic [31:0] ID_VAL  = 32'hE203_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nice_csr_valid,
  output logic                   nice_csr_ready,
  input  logic [31:0]            nice_csr_addr,
  input  logic                   nice_csr_wr,
  input  logic [31:0]            nice_csr_wdata,
  output logic [31:0]            nice_csr_rdata,
  output logic [NUM_CSR*32-1:0]  nice_cfg_o
);

  logic [NUM_CSR-1:0][31:0] cfg;
  logic [31:0]              cyc;
  logic [31:0]              acc;
  logic [11:0]              sel_addr;
  logic                     hs;
  logic                     unused_addr_hi;

  assign unused_addr_hi = ^nice_csr_addr[31:12];
  assign nice_cfg_o     = cfg;

  // Read mux; unmapped indices fall through to zero.
  always_comb begin
    nice_csr_rdata = '0;
    for (int i = 0; i < NUM_CSR; i++)
      if (sel_addr == 12'(32'hE00 + i)) nice_csr_rdata = cfg[i];
    if (sel_addr == 12'hE10) nice_csr_rdata = cyc;
    if (sel_addr == 12'hEF0) nice_csr_rdata = ID_VAL;
    if (sel_addr == 12'hEF1) nice_csr_rdata = acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg <= '0;
      cyc <= '0;
      acc <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (hs) begin
        acc <= acc + 32'd1;
        if (nice_csr_wr) begin
          for (int i = 0; i < NUM_CSR; i++)
            if (sel_addr == 12'(32'hE00 + i)) cfg[i] <= nice_csr_wdata;
          // CSR write takes priority over the free-running increment
          if (sel_addr == 12'hE10) cyc <= nice_csr_wdata;
        end
      end
    end
  end

  generate
    if (LAT == 0) begin : g_comb
      assign nice_csr_ready = 1'b1;
      assign sel_addr       = nice_csr_addr[11:0];
      assign hs             = nice_csr_valid;
    end else begin : g_fsm
      typedef enum logic [1:0] {IDLE, BUSY, RDY} state_t;
      localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

      state_t      state;
      logic [3:0]  cnt;
      logic [11:0] lat_addr;
      logic        rdy;
      logic        match;

      assign match = (nice_csr_addr[11:0] == lat_addr);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state    <= IDLE;
          cnt      <= '0;
          lat_addr <= '0;
          rdy      <= 1'b0;
        end else begin
          case (state)
            IDLE: if (nice_csr_valid) begin
              lat_addr <= nice_csr_addr[11:0];
              if (LAT == 1) begin
                state <= RDY;
                rdy   <= 1'b1;
              end else begin
                state <= BUSY;
                cnt   <= LAT_M1;
              end
            end
            BUSY: if (cnt == 4'd1) begin
              state <= RDY;
              rdy   <= 1'b1;
            end else begin
              cnt <= cnt - 4'd1;
            end
            RDY: if (nice_csr_valid) begin
              if (match) begin
                state <= IDLE;
                rdy   <= 1'b0;
              end else begin
                // New address while ready: restart the latency as if from IDLE
                lat_addr <= nice_csr_addr[11:0];
                if (LAT != 1) begin
                  state <= BUSY;
                  rdy   <= 1'b0;
                  cnt   <= LAT_M1;
                end
              end
            end
            default: begin
              state <= IDLE;
              rdy   <= 1'b0;
            end
          endcase
        end
      end

      assign nice_csr_ready = rdy;
      assign sel_addr       = lat_addr;
      assign hs             = rdy & nice_csr_valid & match;
    end
  endgenerate

endmodule

// File: tb/tb_e203_nice_csr_resp.sv
// Bench: four responders with LAT=0..3 checked against a register-level model
// of the CSR window (values, access count, cycle count from elapsed cycles).
module tb_e203_nice_csr_resp;

  logic         clk;
  logic         rst;
  logic         valid [4];
  logic         ready [4];
  logic [31:0]  addr  [4];
  logic         wr    [4];
  logic [31:0]  wdata [4];
  logic [31:0]  rdata [4];
  logic [127:0] cfg_o [4];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // model state per instance
  logic [31:0] m_cfg   [4][4];
  logic [31:0] m_acc   [4];
  logic [31:0] m_cbase [4];
  int          m_cat   [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    e203_nice_csr_resp #(.LAT(g), .NUM_CSR(4), .ID_VAL(32'hE203_0001)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .nice_csr_valid (valid[g]),
      .nice_csr_ready (ready[g]),
      .nice_csr_addr  (addr[g]),
      .nice_csr_wr    (wr[g]),
      .nice_csr_wdata (wdata[g]),
      .nice_csr_rdata (rdata[g]),
      .nice_cfg_o     (cfg_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int k, input logic [11:0] a);
    if (a[11:2] == 10'h380) return m_cfg[k][a[1:0]];
    if (a == 12'hE10)       return m_cbase[k] + 32'(cycle - m_cat[k]);
    if (a == 12'hEF0)       return 32'hE203_0001;
    if (a == 12'hEF1)       return m_acc[k];
    return 32'h0;
  endfunction

  function automatic logic [127:0] exp_cfg(input int k);
    return {m_cfg[k][3], m_cfg[k][2], m_cfg[k][1], m_cfg[k][0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_acc[k]   = 0;
      m_cbase[k] = 0;
      m_cat[k]   = cycle;
      for (int i = 0; i < 4; i++) m_cfg[k][i] = 0;
    end
  endtask

  // handshake in the current cycle: account it and apply any write
  task automatic commit(input int k, input logic [11:0] a, input logic w, input logic [31:0] d);
    m_acc[k] = m_acc[k] + 1;
    if (w) begin
      if (a[11:2] == 10'h380) m_cfg[k][a[1:0]] = d;
      else if (a == 12'hE10) begin
        m_cbase[k] = d;
        m_cat[k]   = cycle + 1;
      end
    end
  endtask

  // Issue a request on instance k (LAT=k) and hold it until ready.
  task automatic req(input int k, input logic [31:0] a, input logic w,
                     input logic [31:0] d, output logic [31:0] rd);
    int n;
    valid[k] = 1'b1; addr[k] = a; wr[k] = w; wdata[k] = d;
    n = 0;
    #1;
    while (ready[k] !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("latency", 128'(n), 128'(k));
    rd = rdata[k];
    chk("rdata", rdata[k], exp_read(k, a[11:0]));
    commit(k, a[11:0], w, d);
    @(negedge clk);
    valid[k] = 1'b0; wr[k] = 1'b0;
    #1;
    if (k > 0) chk("ready_after_hs", ready[k], 0);
    chk("cfg_o", cfg_o[k], exp_cfg(k));
  endtask

  initial begin
    logic [31:0] rd, r, a, a0;
    logic [11:0] a12;
    int k, pick, n;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 0; addr[i] = 0; wr[i] = 0; wdata[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int i = 1; i < 4; i++) chk("reset_ready", ready[i], 0);
    for (int i = 0; i < 4; i++) begin
      chk("reset_rdata", rdata[i], 0);
      chk("reset_cfg_o", cfg_o[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // LAT=1 write, then ACC read
    req(1, 32'h0000_0E02, 1, 32'hDEAD_BEEF, rd);
    chk("lat1_cfg2", cfg_o[1][95:64], 32'hDEAD_BEEF);
    req(1, 32'h0000_0EF1, 0, 0, rd);
    chk("lat1_acc", rd, 1);

    // LAT=3 ID read, ignored write, re-read
    req(3, 32'h0000_0EF0, 0, 0, rd);
    chk("lat3_id", rd, 32'hE203_0001);
    req(3, 32'h0000_0EF0, 1, 0, rd);
    req(3, 32'h0000_0EF0, 0, 0, rd);
    chk("lat3_id_ro", rd, 32'hE203_0001);

    // LAT=2 CYC write then read after one idle cycle
    req(2, 32'h0000_0E10, 1, 32'h100, rd);
    @(negedge clk);
    req(2, 32'h0000_0E10, 0, 0, rd);
    chk("lat2_cyc", rd, 32'h103);

    // LAT=2 address change while ready
    a0 = m_acc[2];
    valid[2] = 1; addr[2] = 32'h0E00; wr[2] = 1; wdata[2] = 32'hAAAA_0000;
    @(negedge clk); @(negedge clk); #1;
    chk("mm_ready", ready[2], 1);
    addr[2] = 32'h0E01; wdata[2] = 32'h5555_1234;
    @(negedge clk); #1;
    chk("mm_drop", ready[2], 0);
    @(negedge clk); #1;
    chk("mm_rise", ready[2], 1);
    chk("mm_rdata", rdata[2], exp_read(2, 12'hE01));
    commit(2, 12'hE01, 1, 32'h5555_1234);
    @(negedge clk);
    valid[2] = 0; wr[2] = 0;
    #1;
    chk("mm_cfg1", cfg_o[2][63:32], 32'h5555_1234);
    chk("mm_cfg0", cfg_o[2][31:0], 0);
    req(2, 32'h0000_0EF1, 0, 0, rd);
    chk("mm_acc", rd, a0 + 1);

    // LAT=0 back-to-back writes
    for (int i = 0; i < 4; i++) begin
      req(0, 32'h0E00 + i, 1, 32'(i + 1), rd);
      chk("lat0_ready", ready[0], 1);
    end
    chk("lat0_cfg", cfg_o[0], {32'd4, 32'd3, 32'd2, 32'd1});
    req(0, 32'h0000_0EF1, 0, 0, rd);
    chk("lat0_acc", rd, 4);
    req(0, 32'h0000_0E55, 0, 0, rd);
    chk("lat0_unmapped", rd, 0);

    // LAT=3 reset in BUSY
    valid[3] = 1; addr[3] = 32'h0E01; wr[3] = 1; wdata[3] = 32'hC0FF_EE01;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", ready[3], 0);
    chk("rst_cfg1", cfg_o[3][63:32], 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n = 0;
    #1;
    while (ready[3] !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("rst_latency", 128'(n), 3);
    commit(3, 12'hE01, 1, 32'hC0FF_EE01);
    @(negedge clk);
    valid[3] = 0; wr[3] = 0;
    #1;
    chk("rst_cfg1_after", cfg_o[3][63:32], 32'hC0FF_EE01);

    // randomized traffic across all instances
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 3);
      pick = $urandom_range(0, 7);
      r = $urandom;
      case (pick)
        4:       a12 = 12'hE10;
        5:       a12 = 12'hEF0;
        6:       a12 = 12'hEF1;
        7:       a12 = r[11:0];
        default: a12 = 12'(32'hE00 + pick);
      endcase
      r = $urandom;
      a = {r[31:12], a12};
      req(k, a, 1'($urandom_range(0, 1)), $urandom, rd);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
